// File: rtl/uart_pkg.sv
// Shared UART parity definitions: parity-mode codes, RX parity FSM states and
// the expected-parity function used by both the TX and RX paths.
package uart_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } rx_par_state_t;

    // acc_xor is the XOR-reduction of the data bits
    function automatic logic exp_parity(input logic acc_xor, input logic [1:0] par_type);
        logic p;
        case (par_type)
            PAR_EVEN:  p = acc_xor;
            PAR_ODD:   p = ~acc_xor;
            PAR_MARK:  p = 1'b1;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/parity_rx_accum.sv
// Purpose: bit-serial RX parity accumulator, bit counter and frame FSM.
// Latency: rx_done/rx_par_err registered, one cycle after the last valid bit.
// Backpressure: none; every rx_bit_valid pulse is consumed, rx_start always wins.
module parity_rx_accum
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       par_en,
    input  logic [1:0] par_type,
    input  logic       rx_start,
    input  logic       rx_bit_valid,
    input  logic       rx_bit,
    output logic       rx_busy,
    output logic       rx_done,
    output logic       rx_par_err
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_par_state_t    state;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic             cfg_en;
    logic [1:0]       cfg_type;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            cfg_en     <= 1'b0;
            cfg_type   <= PAR_EVEN;
            rx_busy    <= 1'b0;
            rx_done    <= 1'b0;
            rx_par_err <= 1'b0;
        end else begin
            rx_done    <= 1'b0;
            rx_par_err <= 1'b0;
            // A start pulse restarts from any state and swallows a coincident bit
            if (rx_start) begin
                state    <= DATA;
                acc      <= 1'b0;
                cnt      <= '0;
                cfg_en   <= par_en;
                cfg_type <= par_type;
                rx_busy  <= 1'b1;
            end else if (rx_bit_valid) begin
                case (state)
                    DATA: begin
                        acc <= acc ^ rx_bit;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_BIT) begin
                            if (cfg_en) begin
                                state <= PARITY;
                            end else begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                                rx_done <= 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        rx_par_err <= (rx_bit != exp_parity(acc, cfg_type));
                        rx_done    <= 1'b1;
                        rx_busy    <= 1'b0;
                        state      <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_parity_unit.sv
// Purpose: UART parity generator (parallel TX) and checker (serial RX) with sticky error.
// Latency: tx_parity one cycle after tx_load; RX result one cycle after the last bit.
// Backpressure: none; strobes are accepted every cycle, err_sticky set wins over err_clr.
module uart_parity_unit
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  par_en,
    input  logic [1:0]            par_type,
    input  logic                  tx_load,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_parity,
    input  logic                  rx_start,
    input  logic                  rx_bit_valid,
    input  logic                  rx_bit,
    output logic                  rx_busy,
    output logic                  rx_done,
    output logic                  rx_par_err,
    output logic                  err_sticky,
    input  logic                  err_clr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_parity <= 1'b0;
        end else if (tx_load) begin
            tx_parity <= par_en & exp_parity(^tx_data, par_type);
        end
    end

    parity_rx_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_rx_accum (
        .clk          (clk),
        .rst          (rst),
        .par_en       (par_en),
        .par_type     (par_type),
        .rx_start     (rx_start),
        .rx_bit_valid (rx_bit_valid),
        .rx_bit       (rx_bit),
        .rx_busy      (rx_busy),
        .rx_done      (rx_done),
        .rx_par_err   (rx_par_err)
    );

    // Set from the registered error so an err_clr in the rx_done cycle loses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= 1'b0;
        end else if (rx_done && rx_par_err) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_parity_unit.sv
// Randomized bench for uart_parity_unit: 8-bit and 5-bit instances against a
// popcount-based reference of the parity rules and frame sequencing.
module tb_uart_parity_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       par_en = 1'b0;
    logic [1:0] par_type = 2'b00;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_start = 1'b0;
    logic       rx_bit_valid = 1'b0;
    logic       rx_bit = 1'b0;
    logic       err_clr = 1'b0;
    logic       tx_parity, rx_busy, rx_done, rx_par_err, err_sticky;
    logic       w5_tx_parity, w5_rx_busy, w5_rx_done, w5_rx_par_err, w5_err_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_parity_unit #(.DATA_WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .par_en(par_en), .par_type(par_type),
        .tx_load(tx_load), .tx_data(tx_data), .tx_parity(tx_parity),
        .rx_start(rx_start), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
        .rx_busy(rx_busy), .rx_done(rx_done), .rx_par_err(rx_par_err),
        .err_sticky(err_sticky), .err_clr(err_clr)
    );

    uart_parity_unit #(.DATA_WIDTH(5), .CNT_W(3)) dut5 (
        .clk(clk), .rst(rst), .par_en(par_en), .par_type(par_type),
        .tx_load(tx_load), .tx_data(tx_data[4:0]), .tx_parity(w5_tx_parity),
        .rx_start(rx_start), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
        .rx_busy(w5_rx_busy), .rx_done(w5_rx_done), .rx_par_err(w5_rx_par_err),
        .err_sticky(w5_err_sticky), .err_clr(err_clr)
    );

    // Reference parity from the count of ones in the word
    function automatic logic ref_par(input int ones, input logic [1:0] t);
        case (t)
            2'd0:    return logic'(ones % 2);
            2'd1:    return logic'(1 - (ones % 2));
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one 8-bit-instance frame and reports what the DUT showed along the way
    task automatic run_frame(input logic [7:0] d, input logic pb, input logic en,
                             input logic [1:0] t, input int maxgap, input logic scramble,
                             output int early_done, output int busy_drop,
                             output logic done_last, output logic err_last, output logic busy_last);
        int nb;
        par_en = en; par_type = t; rx_start = 1'b1;
        step();
        rx_start = 1'b0;
        if (scramble) begin
            par_en = 1'($urandom); par_type = 2'($urandom);
        end
        nb = en ? 9 : 8;
        early_done = 0; busy_drop = 0;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                step();
                early_done += int'(rx_done);
                busy_drop  += int'(!rx_busy);
            end
            rx_bit_valid = 1'b1;
            rx_bit = (i < 8) ? d[i] : pb;
            step();
            rx_bit_valid = 1'b0;
            if (i < nb - 1) begin
                early_done += int'(rx_done);
                busy_drop  += int'(!rx_busy);
            end
        end
        done_last = rx_done; err_last = rx_par_err; busy_last = rx_busy;
    endtask

    task automatic test_reset();
        logic [9:0] o;
        o = {tx_parity, rx_busy, rx_done, rx_par_err, err_sticky,
             w5_tx_parity, w5_rx_busy, w5_rx_done, w5_rx_par_err, w5_err_sticky};
        n_cmp++;
        if (o !== 10'b0) begin n_bad++; $display("FAIL reset_outputs: got %b want %b", o, 10'b0); end
    endtask

    task automatic test_tx();
        logic [7:0] vd [5];
        logic [1:0] vt [5];
        logic       ve [5];
        logic       vx [5];
        logic       held, e8, e5;
        vd = '{8'hA5, 8'hA5, 8'h00, 8'hFF, 8'hA5};
        vt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ve = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vx = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            par_en = ve[i]; par_type = vt[i]; tx_data = vd[i]; tx_load = 1'b1;
            step();
            tx_load = 1'b0;
            n_cmp++;
            if (tx_parity !== vx[i]) begin n_bad++; $display("FAIL tx_vector%0d: got %b want %b", i, tx_parity, vx[i]); end
        end
        for (int i = 0; i < 30; i++) begin
            par_en = 1'($urandom); par_type = 2'($urandom); tx_data = 8'($urandom); tx_load = 1'b1;
            e8 = par_en ? ref_par($countones(tx_data), par_type) : 1'b0;
            e5 = par_en ? ref_par($countones(tx_data[4:0]), par_type) : 1'b0;
            step();
            tx_load = 1'b0;
            n_cmp++;
            if (tx_parity !== e8) begin n_bad++; $display("FAIL tx_rand8 #%0d: got %b want %b", i, tx_parity, e8); end
            n_cmp++;
            if (w5_tx_parity !== e5) begin n_bad++; $display("FAIL tx_rand5 #%0d: got %b want %b", i, w5_tx_parity, e5); end
            held = e8;
            tx_data = ~tx_data; par_type = ~par_type;
            step();
            n_cmp++;
            if (tx_parity !== held) begin n_bad++; $display("FAIL tx_hold #%0d: got %b want %b", i, tx_parity, held); end
        end
    endtask

    task automatic test_rx_fixed();
        int ed, bd;
        logic dl, el, bl;
        // even, 8'h07 has three ones, parity 1 is correct
        run_frame(8'h07, 1'b1, 1'b1, 2'd0, 0, 1'b0, ed, bd, dl, el, bl);
        n_cmp++;
        if ({ed != 0, bd != 0, dl, el, bl} !== 5'b00100) begin
            n_bad++; $display("FAIL rx_good: early=%0d busydrop=%0d done=%b err=%b busy=%b want 0 0 1 0 0", ed, bd, dl, el, bl);
        end
        step();
        n_cmp++;
        if ({rx_done, err_sticky} !== 2'b00) begin n_bad++; $display("FAIL rx_good_after: done,sticky=%b want 00", {rx_done, err_sticky}); end
        // odd, 8'h03 needs parity 1, sending 0 is an error
        run_frame(8'h03, 1'b0, 1'b1, 2'd1, 2, 1'b0, ed, bd, dl, el, bl);
        n_cmp++;
        if ({ed != 0, dl, el} !== 3'b011) begin n_bad++; $display("FAIL rx_bad: early=%0d done=%b err=%b want 0 1 1", ed, dl, el); end
        step();
        n_cmp++;
        if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL rx_bad_sticky: got %b want 1", err_sticky); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        n_cmp++;
        if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clear: got %b want 0", err_sticky); end
        // err_clr coinciding with the rx_done cycle of a bad frame
        run_frame(8'h03, 1'b0, 1'b1, 2'd1, 0, 1'b0, ed, bd, dl, el, bl);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        n_cmp++;
        if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_set_wins: got %b want 1", err_sticky); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        n_cmp++;
        if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clear_later: got %b want 0", err_sticky); end
    endtask

    task automatic test_rx_random();
        int ed, bd;
        logic dl, el, bl, exp_err, sticky_m;
        logic [7:0] d;
        logic [1:0] t;
        logic en, pb;
        sticky_m = err_sticky;
        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom); t = 2'($urandom); en = 1'($urandom); pb = 1'($urandom);
            exp_err = en ? (pb != ref_par($countones(d), t)) : 1'b0;
            run_frame(d, pb, en, t, 3, 1'b1, ed, bd, dl, el, bl);
            n_cmp++;
            if ({ed != 0, bd != 0, dl, el, bl} !== {3'b001, exp_err, 1'b0}) begin
                n_bad++;
                $display("FAIL rx_rand #%0d: early=%0d busydrop=%0d done=%b err=%b busy=%b want 0 0 1 %b 0",
                         i, ed, bd, dl, el, bl, exp_err);
            end
            step();
            sticky_m = sticky_m | exp_err;
            n_cmp++;
            if (err_sticky !== sticky_m) begin n_bad++; $display("FAIL rx_rand_sticky #%0d: got %b want %b", i, err_sticky, sticky_m); end
            if ($urandom_range(0, 2) == 0) begin
                err_clr = 1'b1; step(); err_clr = 1'b0;
                sticky_m = 1'b0;
            end
        end
    endtask

    task automatic test_restart();
        int dones;
        logic [7:0] d;
        logic err_seen;
        dones = 0; err_seen = 1'b0;
        par_en = 1'b1; par_type = 2'd0;
        rx_start = 1'b1; step(); rx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_bit_valid = 1'b1; rx_bit = 1'($urandom); step();
            dones += int'(rx_done);
        end
        // restart carrying a bit that must be ignored
        rx_start = 1'b1; rx_bit_valid = 1'b1; rx_bit = 1'b1; step();
        rx_start = 1'b0; dones += int'(rx_done);
        d = 8'h01;
        for (int i = 0; i < 9; i++) begin
            rx_bit = (i < 8) ? d[i] : 1'b1; step();
            dones += int'(rx_done);
            err_seen |= rx_done & rx_par_err;
        end
        rx_bit_valid = 1'b0;
        repeat (3) begin step(); dones += int'(rx_done); end
        n_cmp++;
        if (dones !== 1) begin n_bad++; $display("FAIL restart_done_count: got %0d want 1", dones); end
        n_cmp++;
        if (err_seen !== 1'b0) begin n_bad++; $display("FAIL restart_err: got %b want 0", err_seen); end
        dones = 0;
        rx_bit_valid = 1'b1;
        repeat (12) begin rx_bit = 1'($urandom); step(); dones += int'(rx_done) + int'(rx_busy); end
        rx_bit_valid = 1'b0;
        n_cmp++;
        if (dones !== 0) begin n_bad++; $display("FAIL idle_bits_ignored: got %0d busy/done cycles want 0", dones); end
    endtask

    task automatic test_back_to_back();
        int ed, bd;
        logic dl1, el1, bl1, dl2, el2, bl2;
        run_frame(8'h5A, 1'b1, 1'b1, 2'd1, 0, 1'b0, ed, bd, dl1, el1, bl1);
        run_frame(8'hC3, 1'b1, 1'b1, 2'd0, 0, 1'b0, ed, bd, dl2, el2, bl2);
        n_cmp++;
        if ({dl1, el1} !== 2'b10) begin n_bad++; $display("FAIL b2b_first: done,err=%b want 10", {dl1, el1}); end
        n_cmp++;
        if ({ed != 0, dl2, el2, bl2} !== 4'b0110) begin
            n_bad++; $display("FAIL b2b_second: early=%0d done=%b err=%b busy=%b want 0 1 1 0", ed, dl2, el2, bl2);
        end
    endtask

    task automatic test_async_reset();
        int ed, bd, dones;
        logic dl, el, bl;
        par_en = 1'b1; par_type = 2'd2; tx_load = 1'b1; step(); tx_load = 1'b0;
        run_frame(8'h00, 1'b1, 1'b1, 2'd1, 0, 1'b0, ed, bd, dl, el, bl);
        step();
        rx_start = 1'b1; step(); rx_start = 1'b0;
        for (int i = 0; i < 3; i++) begin rx_bit_valid = 1'b1; rx_bit = 1'b1; step(); end
        rx_bit_valid = 1'b0;
        n_cmp++;
        if ({tx_parity, rx_busy, err_sticky} !== 3'b111) begin
            n_bad++; $display("FAIL pre_reset_state: got %b want 111", {tx_parity, rx_busy, err_sticky});
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({tx_parity, rx_busy, rx_done, rx_par_err, err_sticky} !== 5'b0) begin
            n_bad++; $display("FAIL async_reset: got %b want 00000", {tx_parity, rx_busy, rx_done, rx_par_err, err_sticky});
        end
        step(); step();
        rst = 1'b1;
        dones = 0;
        rx_bit_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin rx_bit = 1'($urandom); step(); dones += int'(rx_done) + int'(rx_busy); end
        rx_bit_valid = 1'b0;
        step();
        dones += int'(rx_done);
        n_cmp++;
        if (dones !== 0) begin n_bad++; $display("FAIL post_reset_no_done: got %0d want 0", dones); end
    endtask

    task automatic test_width5();
        logic [4:0] d;
        int early;
        logic exp_err;
        for (int f = 0; f < 2; f++) begin
            d = 5'($urandom);
            par_en = (f == 1); par_type = 2'd0;
            exp_err = 1'b0;
            rx_start = 1'b1; step(); rx_start = 1'b0;
            early = 0;
            for (int i = 0; i < 5 + f; i++) begin
                rx_bit_valid = 1'b1;
                // the parity bit is sent inverted so that frame must flag an error
                rx_bit = (i < 5) ? d[i] : ~ref_par($countones(d), 2'd0);
                step();
                if (i < 4 + f) early += int'(w5_rx_done);
            end
            if (f == 1) exp_err = 1'b1;
            rx_bit_valid = 1'b0;
            n_cmp++;
            if ({early != 0, w5_rx_done, w5_rx_par_err, w5_rx_busy} !== {2'b01, exp_err, 1'b0}) begin
                n_bad++;
                $display("FAIL width5_frame%0d: early=%0d done=%b err=%b busy=%b want 0 1 %b 0",
                         f, early, w5_rx_done, w5_rx_par_err, w5_rx_busy, exp_err);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        step();
        test_tx();
        test_rx_fixed();
        test_rx_random();
        test_restart();
        test_back_to_back();
        test_async_reset();
        test_width5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
